// File: rtl/sram_req_ctrl.sv
// SRAM request controller: front-end for a single-port SRAM macro with byte-strobe
// read-modify-write and an in-order read-response FIFO.
module sram_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                    clk0,
  input  logic                    rst0,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    sram_csb0,
  output logic                    sram_web0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  input  logic [DATA_WIDTH-1:0]   sram_dout0,
  output logic [1:0]              o_dbg_state
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(RSP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RMW_W1 = 2'd1,
    S_RMW_W2 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_rd_p1;
  logic                  r_rd_p2;
  logic [ADDR_WIDTH-1:0] r_rmw_addr;
  logic [DATA_WIDTH-1:0] r_rmw_wdata;
  logic [NB-1:0]         r_rmw_strb;

  logic [CW:0]           w_occupancy;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_partial;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_cmd_en;
  logic                  w_cmd_we;
  logic                  w_cmd_rsp;
  logic                  w_rmw_start;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [DATA_WIDTH-1:0] w_cmd_din;
  logic [DATA_WIDTH-1:0] w_merged;

  // Handshakes: a request transfers on a posedge where req_valid && req_ready;
  // a response pops on a posedge where rsp_valid && rsp_ready. Neither ready
  // looks at its own valid, and ready only rises when a slot is reserved.
  assign w_occupancy = {1'b0, r_count} + (CW+1)'(r_rd_p1) + (CW+1)'(r_rd_p2);
  assign w_ready     = (r_state == S_IDLE) && !rst0 && (w_occupancy < DEPTH_L);
  assign req_ready   = w_ready;
  assign w_accept    = req_valid && w_ready;
  assign w_partial   = (|req_wstrb) && !(&req_wstrb);
  assign o_dbg_state = r_state;

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && req_we && w_partial) w_state_nxt = S_RMW_W1;
      S_RMW_W1: w_state_nxt = S_RMW_W2;
      S_RMW_W2: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_en    = 1'b0;
    w_cmd_we    = 1'b0;
    w_cmd_rsp   = 1'b0;
    w_rmw_start = 1'b0;
    w_cmd_addr  = req_addr;
    w_cmd_din   = req_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!req_we) begin
            w_cmd_en  = 1'b1;
            w_cmd_rsp = 1'b1;
          end else if (&req_wstrb) begin
            w_cmd_en = 1'b1;
            w_cmd_we = 1'b1;
          end else if (w_partial) begin
            // Read half of the RMW: no response tag, data consumed by the merge.
            w_cmd_en    = 1'b1;
            w_rmw_start = 1'b1;
          end
        end
      end
      S_RMW_W2: begin
        w_cmd_en   = 1'b1;
        w_cmd_we   = 1'b1;
        w_cmd_addr = r_rmw_addr;
        w_cmd_din  = w_merged;
      end
      default: begin
        w_cmd_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_merged = sram_dout0;
    for (int b = 0; b < NB; b++) begin
      if (r_rmw_strb[b]) w_merged[b*8 +: 8] = r_rmw_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      sram_csb0  <= 1'b1;
      sram_web0  <= 1'b1;
      sram_addr0 <= '0;
      sram_din0  <= '0;
    end else if (w_cmd_en) begin
      sram_csb0  <= 1'b0;
      sram_web0  <= ~w_cmd_we;
      sram_addr0 <= w_cmd_addr;
      if (w_cmd_we) sram_din0 <= w_cmd_din;
    end else begin
      sram_csb0 <= 1'b1;
      sram_web0 <= 1'b1;
    end
  end

  // Two-stage tag pipe: stage 2 marks the edge where the macro output is valid.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
    end else begin
      r_rd_p1 <= w_cmd_en && w_cmd_rsp;
      r_rd_p2 <= r_rd_p1;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      r_rmw_addr  <= '0;
      r_rmw_wdata <= '0;
      r_rmw_strb  <= '0;
    end else if (w_rmw_start) begin
      r_rmw_addr  <= req_addr;
      r_rmw_wdata <= req_wdata;
      r_rmw_strb  <= req_wstrb;
    end
  end

  assign w_push    = r_rd_p2;
  assign w_pop     = (r_count != '0) && rsp_ready;
  assign rsp_valid = (r_count != '0);
  assign rsp_rdata = r_fifo[r_rd_ptr];

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= sram_dout0;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule
